ldm_stm_seq: RTL and testbench

LDM_STM_SEQ -- requirements
Module: ldm_stm_seq

---
 rtl/ldm_stm_seq_pkg.sv | 22 ++
 rtl/ldm_stm_seq_prio.sv | 20 ++
 rtl/ldm_stm_seq.sv | 193 +++++++++++++++++++
 tb/tb_ldm_stm_seq.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ldm_stm_seq_pkg.sv
// Shared types and constants for the LDM/STM block-transfer sequencer.
package ldm_stm_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_WB   = 2'd2,
        ST_DONE = 2'd3
    } seq_state_e;

    localparam logic [31:0] WORD_STRIDE = 32'd4;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] cnt;
        cnt = '0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + {4'd0, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/ldm_stm_seq_prio.sv
// Lowest-set-bit picker: next register to transfer and the mask left after it.
module ldm_stm_prio (
    input  logic [15:0] mask,
    output logic [3:0]  idx,
    output logic [15:0] rest
);

    // NOTE: combinational outputs get a default before any conditional update so no latch is inferred.
    always_comb begin
        idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (mask[i]) begin
                idx = 4'(i);
            end
        end
    end

    assign rest = mask & (mask - 16'd1);

endmodule

// File: rtl/ldm_stm_seq.sv
// LDM/STM multi-register transfer sequencer; base writeback is enabled by defining
// LDMSTM_WRITEBACK_EN, otherwise XFER goes straight to DONE and rn is unused.
module ldm_stm_seq
    import ldm_stm_seq_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        is_load,
    input  logic [15:0] reglist,
    input  logic [3:0]  rn,
    input  logic [31:0] base,
    input  logic        up,
    input  logic        pre,
    output logic [3:0]  ra,
    input  logic [31:0] rd,
    output logic [3:0]  wa3,
    output logic        we3,
    output logic [31:0] wd3,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        pc_load,
    output logic [31:0] pc_data,
    output logic        busy,
    output logic        done
);

    seq_state_e  state_q, state_d;
    logic [15:0] mask_q, mask_d;
    logic [31:0] addr_q, addr_d;
    logic        is_load_q, is_load_d;

    logic [3:0]  cur_idx;
    logic [15:0] mask_rest;
    logic [4:0]  n_regs;
    logic [31:0] span;
    logic [31:0] first_addr;
    seq_state_e  after_xfer;

    ldm_stm_prio u_prio (
        .mask (mask_q),
        .idx  (cur_idx),
        .rest (mask_rest)
    );

    assign n_regs = popcount16(reglist);
    assign span   = 32'(n_regs) * WORD_STRIDE;

    // Transfers always run upward from the lowest address, so a decrementing block starts below base.
    always_comb begin
        first_addr = base;
        case ({up, pre})
            2'b11:   first_addr = base + WORD_STRIDE;
            2'b10:   first_addr = base;
            2'b01:   first_addr = base - span;
            default: first_addr = base - span + WORD_STRIDE;
        endcase
    end

`ifdef LDMSTM_WRITEBACK_EN
    logic        wb_en_q, wb_en_d;
    logic [3:0]  rn_q, rn_d;
    logic [31:0] wb_data_q, wb_data_d;

    assign after_xfer = wb_en_q ? ST_WB : ST_DONE;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wb_en_q   <= 1'b0;
            rn_q      <= '0;
            wb_data_q <= '0;
        end else begin
            wb_en_q   <= wb_en_d;
            rn_q      <= rn_d;
            wb_data_q <= wb_data_d;
        end
    end

    // A loaded base register beats the writeback value; an empty list has nothing to write back.
    always_comb begin
        wb_en_d   = wb_en_q;
        rn_d      = rn_q;
        wb_data_d = wb_data_q;
        if (state_q == ST_IDLE && start) begin
            wb_en_d   = (n_regs != 5'd0) && !(is_load && reglist[rn]);
            rn_d      = rn;
            wb_data_d = up ? (base + span) : (base - span);
        end
    end
`else
    logic unused_rn;
    assign unused_rn  = ^rn;
    assign after_xfer = ST_DONE;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            mask_q    <= '0;
            addr_q    <= '0;
            is_load_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            addr_q    <= addr_d;
            is_load_q <= is_load_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        addr_d    = addr_q;
        is_load_d = is_load_q;
        ra        = '0;
        wa3       = '0;
        we3       = 1'b0;
        wd3       = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        pc_load   = 1'b0;
        pc_data   = '0;
        done      = 1'b0;
        busy      = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_XFER;
                    mask_d    = reglist;
                    addr_d    = first_addr;
                    is_load_d = is_load;
                end
            end
            ST_XFER: begin
                if (mask_q == 16'd0) begin
                    state_d = after_xfer;
                end else begin
                    mem_req  = 1'b1;
                    mem_we   = !is_load_q;
                    mem_addr = addr_q;
                    if (!is_load_q) begin
                        ra        = cur_idx;
                        mem_wdata = rd;
                    end
                    if (mem_ready) begin
                        mask_d = mask_rest;
                        addr_d = addr_q + WORD_STRIDE;
                        if (is_load_q) begin
                            if (cur_idx == 4'd15) begin
                                pc_load = 1'b1;
                                pc_data = mem_rdata;
                            end else begin
                                we3 = 1'b1;
                                wa3 = cur_idx;
                                wd3 = mem_rdata;
                            end
                        end
                        if (mask_rest == 16'd0) begin
                            state_d = after_xfer;
                        end
                    end
                end
            end
            ST_WB: begin
`ifdef LDMSTM_WRITEBACK_EN
                if (rn_q == 4'd15) begin
                    pc_load = 1'b1;
                    pc_data = wb_data_q;
                end else begin
                    we3 = 1'b1;
                    wa3 = rn_q;
                    wd3 = wb_data_q;
                end
`endif
                state_d = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ldm_stm_seq.sv
// Directed self-checking bench for ldm_stm_seq; expectations adapt to LDMSTM_WRITEBACK_EN.
module tb_ldm_stm_seq;

`ifdef LDMSTM_WRITEBACK_EN
    localparam bit WB = 1'b1;
`else
    localparam bit WB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start, is_load, up, pre, mem_ready;
    logic [15:0] reglist;
    logic [3:0]  rn, ra, wa3;
    logic [31:0] base, rd, wd3, mem_addr, mem_wdata, mem_rdata, pc_data;
    logic        we3, mem_req, mem_we, pc_load, busy, done;

    int checks = 0;
    int fails  = 0;

    logic [31:0] x_addr [17];
    logic [31:0] x_wdata[17];
    logic        x_we   [17];
    logic [3:0]  w_wa   [4];
    logic [31:0] w_wd   [4];
    logic [31:0] pc_d;
    int n_xfer, n_req, n_we3, n_pc, n_done, done_cyc, stall_err, busy_err;

    always #5 clk = ~clk;

    // Register file and memory models
    assign rd        = 32'hA000_0000 | {28'd0, ra};
    assign mem_rdata = mem_addr ^ 32'hD00D_0000;

    ldm_stm_seq dut (
        .clk(clk), .reset_n(reset_n), .start(start), .is_load(is_load),
        .reglist(reglist), .rn(rn), .base(base), .up(up), .pre(pre),
        .ra(ra), .rd(rd), .wa3(wa3), .we3(we3), .wd3(wd3),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .pc_load(pc_load), .pc_data(pc_data), .busy(busy), .done(done)
    );

    // Launch one sequence and log everything it does, cycle numbers counted from the start edge.
    task automatic run_seq(input logic ld, input logic [15:0] rl, input logic [3:0] r,
                           input logic [31:0] b, input logic u, input logic p,
                           input int stall_at, input int stall_len, input int poke_at);
        int stall_cnt;
        logic pend;
        logic [31:0] pa, pw;
        stall_cnt = 0; pend = 1'b0; pa = '0; pw = '0;
        n_xfer = 0; n_req = 0; n_we3 = 0; n_pc = 0; n_done = 0;
        done_cyc = -1; stall_err = 0; busy_err = 0; pc_d = '0;
        for (int i = 0; i < 17; i++) begin
            x_addr[i] = '0; x_wdata[i] = '0; x_we[i] = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            w_wa[i] = '0; w_wd[i] = '0;
        end
        is_load = ld; reglist = rl; rn = r; base = b; up = u; pre = p;
        mem_ready = 1'b1; start = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk);
            #1;
            start = (cyc == poke_at);
            if (cyc == 1) begin
                is_load = ~ld; reglist = ~rl; rn = ~r; base = ~b; up = ~u; pre = ~p;
            end
            if (n_xfer == stall_at && stall_cnt < stall_len) begin
                mem_ready = 1'b0;
                stall_cnt++;
            end else begin
                mem_ready = 1'b1;
            end
            #1;
            if (!busy && done_cyc < 0) busy_err++;
            if (mem_req) begin
                n_req++;
                if (pend && (mem_addr !== pa || mem_wdata !== pw)) stall_err++;
                if (mem_ready && n_xfer < 17) begin
                    x_addr[n_xfer]  = mem_addr;
                    x_wdata[n_xfer] = mem_wdata;
                    x_we[n_xfer]    = mem_we;
                    n_xfer++;
                end
            end
            pend = mem_req && !mem_ready;
            pa   = mem_addr;
            pw   = mem_wdata;
            if (we3) begin
                if (n_we3 < 4) begin
                    w_wa[n_we3] = wa3;
                    w_wd[n_we3] = wd3;
                end
                n_we3++;
            end
            if (pc_load) begin
                pc_d = pc_data;
                n_pc++;
            end
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                if (busy) busy_err++;
                break;
            end
        end
        start = 1'b0;
        mem_ready = 1'b1;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0h expected 0", busy); end
        checks++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %0h expected 0", done); end
        checks++; if (mem_req !== 1'b0) begin fails++; $display("FAIL reset_mem_req: got %0h expected 0", mem_req); end
        checks++; if (we3 !== 1'b0) begin fails++; $display("FAIL reset_we3: got %0h expected 0", we3); end
        checks++; if (pc_load !== 1'b0) begin fails++; $display("FAIL reset_pc_load: got %0h expected 0", pc_load); end
        checks++; if (mem_addr !== 32'd0) begin fails++; $display("FAIL reset_mem_addr: got %0h expected 0", mem_addr); end
        checks++; if (mem_wdata !== 32'd0) begin fails++; $display("FAIL reset_mem_wdata: got %0h expected 0", mem_wdata); end
        checks++; if (wd3 !== 32'd0) begin fails++; $display("FAIL reset_wd3: got %0h expected 0", wd3); end
        @(posedge clk);
        #2 reset_n = 1'b1;
    endtask

    task automatic test_stm_basic();
        run_seq(1'b0, 16'h000F, 4'd15, 32'h100, 1'b1, 1'b0, -1, 0, 0);
        checks++; if (n_xfer !== 4) begin fails++; $display("FAIL stm_count: got %0d expected 4", n_xfer); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (x_addr[i] !== 32'h100 + 32'(4 * i) || x_wdata[i] !== 32'hA000_0000 + 32'(i) || x_we[i] !== 1'b1) begin
                fails++;
                $display("FAIL stm_xfer%0d: got addr %0h data %0h we %0h expected addr %0h data %0h we 1",
                         i, x_addr[i], x_wdata[i], x_we[i], 32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i));
            end
        end
        checks++; if (n_we3 !== 0) begin fails++; $display("FAIL stm_we3_count: got %0d expected 0", n_we3); end
        checks++; if (n_pc !== (WB ? 1 : 0) || pc_d !== (WB ? 32'h110 : 32'h0)) begin
            fails++; $display("FAIL stm_wb_pc: got %0d pulses data %0h expected %0d data %0h",
                              n_pc, pc_d, WB ? 1 : 0, WB ? 32'h110 : 32'h0); end
        checks++; if (done_cyc !== (WB ? 6 : 5)) begin fails++; $display("FAIL stm_done_cycle: got %0d expected %0d", done_cyc, WB ? 6 : 5); end
        checks++; if (n_done !== 1 || busy_err !== 0) begin fails++; $display("FAIL stm_busy_done: got done %0d busy_err %0d expected 1 and 0", n_done, busy_err); end
    endtask

    task automatic test_ldm_down();
        run_seq(1'b1, 16'h8003, 4'd13, 32'h200, 1'b0, 1'b1, -1, 0, 0);
        checks++; if (n_xfer !== 3) begin fails++; $display("FAIL ldm_count: got %0d expected 3", n_xfer); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (x_addr[i] !== 32'h1F4 + 32'(4 * i) || x_we[i] !== 1'b0) begin
                fails++; $display("FAIL ldm_addr%0d: got %0h we %0h expected %0h we 0", i, x_addr[i], x_we[i], 32'h1F4 + 32'(4 * i));
            end
        end
        checks++; if (n_we3 !== (WB ? 3 : 2)) begin fails++; $display("FAIL ldm_we3_count: got %0d expected %0d", n_we3, WB ? 3 : 2); end
        checks++; if (w_wa[0] !== 4'd0 || w_wd[0] !== 32'hD00D_01F4) begin fails++; $display("FAIL ldm_r0: got R%0d=%0h expected R0=d00d01f4", w_wa[0], w_wd[0]); end
        checks++; if (w_wa[1] !== 4'd1 || w_wd[1] !== 32'hD00D_01F8) begin fails++; $display("FAIL ldm_r1: got R%0d=%0h expected R1=d00d01f8", w_wa[1], w_wd[1]); end
        checks++; if (n_pc !== 1 || pc_d !== 32'hD00D_01FC) begin fails++; $display("FAIL ldm_pc: got %0d pulses data %0h expected 1 data d00d01fc", n_pc, pc_d); end
        checks++; if (w_wa[2] !== (WB ? 4'd13 : 4'd0) || w_wd[2] !== (WB ? 32'h1F4 : 32'h0)) begin
            fails++; $display("FAIL ldm_wb: got R%0d=%0h expected R%0d=%0h", w_wa[2], w_wd[2], WB ? 13 : 0, WB ? 32'h1F4 : 32'h0); end
        checks++; if (done_cyc !== (WB ? 5 : 4)) begin fails++; $display("FAIL ldm_done_cycle: got %0d expected %0d", done_cyc, WB ? 5 : 4); end
    endtask

    task automatic test_stall();
        run_seq(1'b0, 16'h0A50, 4'd4, 32'h1000, 1'b1, 1'b1, 1, 3, 0);
        checks++; if (n_xfer !== 4) begin fails++; $display("FAIL stall_count: got %0d expected 4", n_xfer); end
        checks++; if (n_req !== 7) begin fails++; $display("FAIL stall_req_cycles: got %0d expected 7", n_req); end
        checks++; if (stall_err !== 0) begin fails++; $display("FAIL stall_hold: got %0d changes expected 0", stall_err); end
        checks++; if (x_addr[1] !== 32'h1008 || x_wdata[1] !== 32'hA000_0006) begin
            fails++; $display("FAIL stall_xfer1: got %0h/%0h expected 1008/a0000006", x_addr[1], x_wdata[1]); end
        checks++; if (x_addr[3] !== 32'h1010 || x_wdata[3] !== 32'hA000_000B) begin
            fails++; $display("FAIL stall_xfer3: got %0h/%0h expected 1010/a000000b", x_addr[3], x_wdata[3]); end
        checks++; if (n_we3 !== (WB ? 1 : 0) || w_wd[0] !== (WB ? 32'h1010 : 32'h0)) begin
            fails++; $display("FAIL stall_wb: got %0d writes data %0h expected %0d data %0h", n_we3, w_wd[0], WB ? 1 : 0, WB ? 32'h1010 : 32'h0); end
        checks++; if (done_cyc !== (WB ? 9 : 8)) begin fails++; $display("FAIL stall_done_cycle: got %0d expected %0d", done_cyc, WB ? 9 : 8); end
    endtask

    task automatic test_empty();
        run_seq(1'b0, 16'h0000, 4'd3, 32'h10, 1'b1, 1'b0, -1, 0, 0);
        checks++; if (n_req !== 0) begin fails++; $display("FAIL empty_req: got %0d expected 0", n_req); end
        checks++; if (n_we3 !== 0 || n_pc !== 0) begin fails++; $display("FAIL empty_writes: got we3 %0d pc %0d expected 0 0", n_we3, n_pc); end
        checks++; if (done_cyc !== 2) begin fails++; $display("FAIL empty_done_cycle: got %0d expected 2", done_cyc); end
        checks++; if (busy_err !== 0) begin fails++; $display("FAIL empty_busy: got %0d errors expected 0", busy_err); end
    endtask

    task automatic test_reset_mid();
        is_load = 1'b1; reglist = 16'h00F0; rn = 4'd3; base = 32'h300; up = 1'b1; pre = 1'b0;
        mem_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h304) begin
            fails++; $display("FAIL mid_pre_reset: got req %0h addr %0h expected 1 304", mem_req, mem_addr); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || we3 !== 1'b0 || busy !== 1'b0 || mem_addr !== 32'd0 || wd3 !== 32'd0) begin
            fails++; $display("FAIL mid_async_reset: got req %0h we3 %0h busy %0h addr %0h wd3 %0h expected all 0",
                              mem_req, we3, busy, mem_addr, wd3); end
        @(posedge clk); #1 reset_n = 1'b1;
        run_seq(1'b1, 16'h0003, 4'd9, 32'h400, 1'b1, 1'b1, -1, 0, 0);
        checks++; if (n_xfer !== 2 || x_addr[0] !== 32'h404 || x_addr[1] !== 32'h408) begin
            fails++; $display("FAIL mid_new_addrs: got %0d xfers %0h %0h expected 2 404 408", n_xfer, x_addr[0], x_addr[1]); end
        checks++; if (n_we3 !== (WB ? 3 : 2) || w_wa[0] !== 4'd0 || w_wd[0] !== 32'hD00D_0404 || w_wa[1] !== 4'd1) begin
            fails++; $display("FAIL mid_new_we3: got %0d writes first R%0d=%0h second R%0d expected %0d R0=d00d0404 R1",
                              n_we3, w_wa[0], w_wd[0], w_wa[1], WB ? 3 : 2); end
        checks++; if (w_wa[2] !== (WB ? 4'd9 : 4'd0) || w_wd[2] !== (WB ? 32'h408 : 32'h0)) begin
            fails++; $display("FAIL mid_new_wb: got R%0d=%0h expected R%0d=%0h", w_wa[2], w_wd[2], WB ? 9 : 0, WB ? 32'h408 : 32'h0); end
    endtask

    task automatic test_wb_skip();
        run_seq(1'b1, 16'h0004, 4'd2, 32'h80, 1'b1, 1'b0, -1, 0, 0);
        checks++; if (n_xfer !== 1 || x_addr[0] !== 32'h80) begin fails++; $display("FAIL skip_xfer: got %0d addr %0h expected 1 80", n_xfer, x_addr[0]); end
        checks++; if (n_we3 !== 1 || w_wa[0] !== 4'd2 || w_wd[0] !== 32'hD00D_0080) begin
            fails++; $display("FAIL skip_we3: got %0d writes R%0d=%0h expected 1 R2=d00d0080", n_we3, w_wa[0], w_wd[0]); end
        checks++; if (done_cyc !== 2) begin fails++; $display("FAIL skip_done_cycle: got %0d expected 2", done_cyc); end
    endtask

    task automatic test_start_ignored();
        run_seq(1'b0, 16'h0003, 4'd7, 32'h50, 1'b0, 1'b0, -1, 0, 2);
        checks++; if (n_xfer !== 2 || x_addr[0] !== 32'h4C || x_addr[1] !== 32'h50) begin
            fails++; $display("FAIL busy_start_addrs: got %0d xfers %0h %0h expected 2 4c 50", n_xfer, x_addr[0], x_addr[1]); end
        checks++; if (x_wdata[0] !== 32'hA000_0000 || x_wdata[1] !== 32'hA000_0001) begin
            fails++; $display("FAIL busy_start_data: got %0h %0h expected a0000000 a0000001", x_wdata[0], x_wdata[1]); end
        checks++; if (w_wa[0] !== (WB ? 4'd7 : 4'd0) || w_wd[0] !== (WB ? 32'h48 : 32'h0)) begin
            fails++; $display("FAIL busy_start_wb: got R%0d=%0h expected R%0d=%0h", w_wa[0], w_wd[0], WB ? 7 : 0, WB ? 32'h48 : 32'h0); end
        checks++; if (done_cyc !== (WB ? 4 : 3) || n_done !== 1 || busy_err !== 0) begin
            fails++; $display("FAIL busy_start_done: got cycle %0d count %0d busy_err %0d expected %0d 1 0",
                              done_cyc, n_done, busy_err, WB ? 4 : 3); end
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; is_load = 1'b0; reglist = '0; rn = '0;
        base = '0; up = 1'b0; pre = 1'b0; mem_ready = 1'b1;
        test_reset();
        test_stm_basic();
        test_ldm_down();
        test_stall();
        test_empty();
        test_reset_mid();
        test_wb_skip();
        test_start_ignored();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
